// File: rtl/fifo_word_packer.sv
// Packs PACK consecutive entries popped from a synchronous FIFO into one wide word.
// The word is presented on a valid/ready stream. A flush request closes a partial word and marks it last.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_r_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data_out,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int WORD_W = DATA_WIDTH * PACK;
  localparam int CNT_W  = $clog2(PACK + 1);
  localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);
  localparam logic [CNT_W:0]   PACK_OCC = (CNT_W + 1)'(PACK);

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } mode_t;

  mode_t             mode;
  logic [CNT_W-1:0]  fill_cnt;
  logic              rd_pend;
  logic [WORD_W-1:0] lanes;

  logic              out_free;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  cnt_cap;
  logic [WORD_W-1:0] lanes_cap;

  function automatic logic [PACK-1:0] keep_mask(input logic [CNT_W-1:0] cnt);
    logic [PACK-1:0] m;
    for (int i = 0; i < PACK; i++) begin
      m[i] = (i < int'(cnt));
    end
    return m;
  endfunction

  function automatic logic [WORD_W-1:0] lane_mask(input logic [PACK-1:0] keep);
    logic [WORD_W-1:0] m;
    for (int i = 0; i < PACK; i++) begin
      m[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{keep[i]}};
    end
    return m;
  endfunction

  assign out_free  = !m_valid || m_ready;
  assign occupancy = {1'b0, fill_cnt} + {{CNT_W{1'b0}}, rd_pend};

  // A read that lands on a word about to be handed to a free output register is
  // still allowed. The word empties on that edge, so the returning entry starts the
  // next word in lane 0. This keeps the stream at one entry per clock.
  assign fifo_r_en = !rst && !fifo_empty && (mode == FILL) && !flush &&
                     ((occupancy < PACK_OCC) || ((occupancy == PACK_OCC) && out_free));

  // Capture stage: the entry requested last cycle lands in lane fill_cnt
  always_comb begin
    lanes_cap = lanes;
    cnt_cap   = fill_cnt;
    if (rd_pend) begin
      for (int i = 0; i < PACK; i++) begin
        if (fill_cnt == CNT_W'(i)) begin
          lanes_cap[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data_out;
        end
      end
      cnt_cap = fill_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    lanes <= lanes_cap;
  end

  // Output stage: word completion, flush emission and stream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= FILL;
      fill_cnt <= '0;
      rd_pend  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
    end else begin
      rd_pend  <= fifo_r_en;
      fill_cnt <= cnt_cap;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      case (mode)
        FILL: begin
          if (flush) begin
            mode <= FLUSH;
          end
          if ((cnt_cap == PACK_CNT) && out_free) begin
            m_data   <= lanes_cap;
            m_keep   <= '1;
            m_last   <= 1'b0;
            m_valid  <= 1'b1;
            fill_cnt <= '0;
          end
        end
        FLUSH: begin
          if (!rd_pend) begin
            if (fill_cnt == '0) begin
              mode <= FILL;
            end else if (out_free) begin
              m_data   <= lanes & lane_mask(keep_mask(fill_cnt));
              m_keep   <= keep_mask(fill_cnt);
              m_last   <= 1'b1;
              m_valid  <= 1'b1;
              fill_cnt <= '0;
              mode     <= FILL;
            end
          end
        end
        default: mode <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a small behavioural FIFO
// that has a 1-cycle registered read.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            fifo_empty;
  logic            fifo_r_en;
  logic [DW-1:0]   fifo_data_out;
  logic            flush;
  logic [DW*PK-1:0] m_data;
  logic [PK-1:0]   m_keep;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:255];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  logic          rd_empty_seen = 1'b0;

  logic [DW*PK-1:0] got_data [0:7];
  logic [PK-1:0]    got_keep [0:7];
  logic             got_last [0:7];
  int               got_n;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_r_en     (fifo_r_en),
    .fifo_data_out (fifo_data_out),
    .flush         (flush),
    .m_data        (m_data),
    .m_keep        (m_keep),
    .m_last        (m_last),
    .m_valid       (m_valid),
    .m_ready       (m_ready)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_r_en && fifo_empty) rd_empty_seen <= 1'b1;
    if (rst) begin
      rd_ptr        <= wr_ptr;
      fifo_data_out <= '0;
    end else if (fifo_r_en && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic collect(input int ncyc);
    got_n = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (m_valid && m_ready && got_n < 8) begin
        got_data[got_n] = m_data;
        got_keep[got_n] = m_keep;
        got_last[got_n] = m_last;
        got_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    push(8'hE0);
    push(8'hE1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b expected 0", fifo_r_en); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
      checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h expected 0", m_keep); end
      checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", m_data); end
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic exp_re;
    logic exp_v;
    logic [31:0] exp_d;
    tick();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      exp_re = (k < 8);
      exp_v  = (k == 5) || (k == 9);
      exp_d  = (k == 5) ? 32'h04030201 : 32'h08070605;
      checks++; if (fifo_r_en !== exp_re) begin errors++; $display("FAIL stream_r_en cyc %0d: got %b expected %b", k, fifo_r_en, exp_re); end
      checks++; if (m_valid !== exp_v) begin errors++; $display("FAIL stream_valid cyc %0d: got %b expected %b", k, m_valid, exp_v); end
      if (exp_v) begin
        checks++; if (m_data !== exp_d) begin errors++; $display("FAIL stream_data cyc %0d: got %h expected %h", k, m_data, exp_d); end
        checks++; if (m_keep !== 4'hF) begin errors++; $display("FAIL stream_keep cyc %0d: got %h expected f", k, m_keep); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL stream_last cyc %0d: got %b expected 0", k, m_last); end
      end
    end
  endtask

  task automatic test_backpressure();
    int pops;
    logic [31:0] exp_w [0:2];
    exp_w[0] = 32'h13121110;
    exp_w[1] = 32'h17161514;
    exp_w[2] = 32'h1B1A1918;
    pops = 0;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fifo_r_en) pops++;
      if (k >= 5) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h13121110) begin
          errors++; $display("FAIL bp_hold cyc %0d: got valid %b data %h expected 1 13121110", k, m_valid, m_data);
        end
      end
    end
    checks++; if (pops != 8) begin errors++; $display("FAIL bp_pops: got %0d expected 8", pops); end
    checks++; if (8'(wr_ptr - rd_ptr) !== 8'd4) begin errors++; $display("FAIL bp_fifo_left: got %0d expected 4", 8'(wr_ptr - rd_ptr)); end
    checks++; if (m_keep !== 4'hF) begin errors++; $display("FAIL bp_keep: got %h expected f", m_keep); end
    tick();
    m_ready = 1'b1;
    collect(15);
    checks++; if (got_n != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_n) begin
        checks++; if (got_data[i] !== exp_w[i] || got_keep[i] !== 4'hF || got_last[i] !== 1'b0) begin
          errors++; $display("FAIL bp_word%0d: got %h/%h/%b expected %h/f/0", i, got_data[i], got_keep[i], got_last[i], exp_w[i]);
        end
      end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL bp_drained: got empty %b expected 1", fifo_empty); end
  endtask

  task automatic test_partial_flush();
    int v;
    v = 0;
    tick();
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (6) begin
      @(negedge clk);
      if (m_valid) v++;
    end
    checks++; if (v != 0) begin errors++; $display("FAIL pf_premature: got %0d valid cycles expected 0", v); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect(6);
    checks++; if (got_n != 1) begin errors++; $display("FAIL pf_count: got %0d expected 1", got_n); end
    checks++; if (got_data[0] !== 32'h00CCBBAA) begin errors++; $display("FAIL pf_data: got %h expected 00ccbbaa", got_data[0]); end
    checks++; if (got_keep[0] !== 4'b0111) begin errors++; $display("FAIL pf_keep: got %b expected 0111", got_keep[0]); end
    checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL pf_last: got %b expected 1", got_last[0]); end
    tick();
    for (int i = 1; i <= 4; i++) push(8'h30 + 8'(i));
    collect(10);
    checks++; if (got_n != 1) begin errors++; $display("FAIL pf_next_count: got %0d expected 1", got_n); end
    checks++; if (got_data[0] !== 32'h34333231 || got_keep[0] !== 4'hF || got_last[0] !== 1'b0) begin
      errors++; $display("FAIL pf_next_word: got %h/%h/%b expected 34333231/f/0", got_data[0], got_keep[0], got_last[0]);
    end
  endtask

  task automatic test_flush_edges();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect(6);
    checks++; if (got_n != 0) begin errors++; $display("FAIL fe_empty_flush: got %0d words expected 0", got_n); end
    tick();
    push(8'h41); push(8'h42);
    @(negedge clk);
    checks++; if (fifo_r_en !== 1'b1) begin errors++; $display("FAIL fe_first_read: got %b expected 1", fifo_r_en); end
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL fe_flush_blocks_read: got %b expected 0", fifo_r_en); end
    tick();
    flush = 1'b0;
    collect(6);
    checks++; if (got_n != 1) begin errors++; $display("FAIL fe_inflight_count: got %0d expected 1", got_n); end
    checks++; if (got_data[0] !== 32'h00000041 || got_keep[0] !== 4'b0001 || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL fe_inflight_word: got %h/%b/%b expected 00000041/0001/1", got_data[0], got_keep[0], got_last[0]);
    end
    tick();
    push(8'h43); push(8'h44); push(8'h45);
    collect(10);
    checks++; if (got_n != 1) begin errors++; $display("FAIL fe_after_count: got %0d expected 1", got_n); end
    checks++; if (got_data[0] !== 32'h45444342 || got_keep[0] !== 4'hF || got_last[0] !== 1'b0) begin
      errors++; $display("FAIL fe_after_word: got %h/%h/%b expected 45444342/f/0", got_data[0], got_keep[0], got_last[0]);
    end
  endtask

  task automatic test_mid_reset();
    tick();
    push(8'h51); push(8'h52);
    repeat (5) @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b expected 0", m_valid); end
    tick();
    for (int i = 1; i <= 4; i++) push(8'h20 + 8'(i));
    collect(12);
    checks++; if (got_n != 1) begin errors++; $display("FAIL mr_count: got %0d expected 1", got_n); end
    checks++; if (got_data[0] !== 32'h24232221 || got_keep[0] !== 4'hF || got_last[0] !== 1'b0) begin
      errors++; $display("FAIL mr_word: got %h/%h/%b expected 24232221/f/0", got_data[0], got_keep[0], got_last[0]);
    end
  endtask

  task automatic test_no_empty_read();
    checks++; if (rd_empty_seen !== 1'b0) begin errors++; $display("FAIL empty_read: got %b expected 0", rd_empty_seen); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_partial_flush();
    test_flush_edges();
    test_mid_reset();
    test_no_empty_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
